// File: rtl/psram_port_arbiter_if.sv
// Signal bundle between psram_port_arbiter, its two requesters and the PSRAM controller port.
// master = arbiter side, slave = requesters/controller side.
interface psram_port_arbiter_if;
   logic        init_done;
   logic        wr_req;
   logic [20:0] wr_addr;
   logic [31:0] wr_data_in;
   logic [3:0]  wr_mask_in;
   logic        wr_gnt;
   logic        wr_data_rd;
   logic        wr_done;
   logic        rd_req;
   logic [20:0] rd_addr;
   logic        rd_gnt;
   logic [31:0] rd_data_out;
   logic        rd_data_out_valid;
   logic        rd_done;
   logic        cmd;
   logic        cmd_en;
   logic [20:0] addr;
   logic [31:0] wr_data;
   logic [3:0]  data_mask;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        busy;
   logic        error;

   modport master (
      input  init_done, wr_req, wr_addr, wr_data_in, wr_mask_in,
             rd_req, rd_addr, rd_data, rd_data_valid,
      output wr_gnt, wr_data_rd, wr_done, rd_gnt, rd_data_out, rd_data_out_valid,
             rd_done, cmd, cmd_en, addr, wr_data, data_mask, busy, error
   );

   modport slave (
      output init_done, wr_req, wr_addr, wr_data_in, wr_mask_in,
             rd_req, rd_addr, rd_data, rd_data_valid,
      input  wr_gnt, wr_data_rd, wr_done, rd_gnt, rd_data_out, rd_data_out_valid,
             rd_done, cmd, cmd_en, addr, wr_data, data_mask, busy, error
   );
endinterface

// File: rtl/psram_port_arbiter.sv
// Round-robin burst arbiter sharing one PSRAM controller channel between a write and a read
// requester; sequences command, data beats and the post-burst gap, and traps protocol errors.
module psram_port_arbiter #(
   parameter int BURST_BEATS = 8,
   parameter int CMD_GAP     = 14,
   parameter int RD_TIMEOUT  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   psram_port_arbiter_if.master bus
);

   localparam int BEAT_W = $clog2(BURST_BEATS + 1);
   localparam int GAP_W  = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
   localparam int TMO_W  = $clog2(RD_TIMEOUT + 1);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
   localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
   localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(RD_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_RD    = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;
   // With no gap configured a finished burst returns straight to arbitration.
   localparam logic [2:0] S_AFTER = (CMD_GAP > 0) ? S_GAP : S_IDLE;

   logic [2:0]        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              last_wr_q, last_wr_d;
   logic [20:0]       addr_q, addr_d;
   logic              wr_done_q, wr_done_d;
   logic              rd_done_q, rd_done_d;

   logic pick_wr;
   logic in_wr, in_rd, first_wr, first_rd;

   // On a tie the requester that was not served last wins.
   assign pick_wr = bus.wr_req & (~bus.rd_req | ~last_wr_q);

   always_comb begin
      // NOTE: every next-state signal gets a default before the case so no path leaves one
      // unassigned; that is what keeps this block free of inferred latches.
      state_d   = state_q;
      beat_d    = '0;
      gap_d     = '0;
      tmo_d     = '0;
      last_wr_d = last_wr_q;
      addr_d    = addr_q;
      wr_done_d = 1'b0;
      rd_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.rd_data_valid) begin
               state_d = S_ERR;
            end else if (bus.init_done && (bus.wr_req || bus.rd_req)) begin
               last_wr_d = pick_wr;
               addr_d    = pick_wr ? bus.wr_addr : bus.rd_addr;
               state_d   = pick_wr ? S_WR : S_RD;
            end
         end
         S_WR: begin
            if (bus.rd_data_valid) begin
               state_d = S_ERR;
            end else if (beat_q == LAST_BEAT) begin
               state_d   = S_AFTER;
               wr_done_d = 1'b1;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         S_RD: begin
            if (bus.rd_data_valid && (beat_q == LAST_BEAT)) begin
               state_d   = S_AFTER;
               rd_done_d = 1'b1;
            end else if (tmo_q == LAST_TMO) begin
               state_d = S_ERR;
            end else begin
               beat_d = beat_q + {{(BEAT_W-1){1'b0}}, bus.rd_data_valid};
               tmo_d  = tmo_q + TMO_W'(1);
            end
         end
         S_GAP: begin
            if (bus.rd_data_valid) begin
               state_d = S_ERR;
            end else if (gap_q == LAST_GAP) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         gap_q     <= '0;
         tmo_q     <= '0;
         last_wr_q <= 1'b0;
         addr_q    <= '0;
         wr_done_q <= 1'b0;
         rd_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         gap_q     <= gap_d;
         tmo_q     <= tmo_d;
         last_wr_q <= last_wr_d;
         addr_q    <= addr_d;
         wr_done_q <= wr_done_d;
         rd_done_q <= rd_done_d;
      end
   end

   assign in_wr    = (state_q == S_WR);
   assign in_rd    = (state_q == S_RD);
   // The timeout counter is zero only on the first read cycle, so it doubles as the strobe marker.
   assign first_wr = in_wr && (beat_q == '0);
   assign first_rd = in_rd && (tmo_q == '0);

   assign bus.cmd_en            = first_wr || first_rd;
   assign bus.cmd               = first_wr;
   assign bus.wr_gnt            = first_wr;
   assign bus.rd_gnt            = first_rd;
   assign bus.addr              = addr_q;
   assign bus.wr_data_rd        = in_wr;
   assign bus.wr_data           = in_wr ? bus.wr_data_in : '0;
   assign bus.data_mask         = in_wr ? bus.wr_mask_in : '0;
   assign bus.rd_data_out_valid = in_rd && bus.rd_data_valid;
   assign bus.rd_data_out       = bus.rd_data_out_valid ? bus.rd_data : '0;
   assign bus.wr_done           = wr_done_q;
   assign bus.rd_done           = rd_done_q;
   assign bus.busy              = (state_q != S_IDLE);
   assign bus.error             = (state_q == S_ERR);

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Self-checking bench for psram_port_arbiter: a cycle-scheduling model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_psram_port_arbiter;
   localparam int BB  = 8;
   localparam int GAP = 14;
   localparam int TMO = 64;
   localparam int NEVER = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   psram_port_arbiter_if bus();

   psram_port_arbiter #(.BURST_BEATS(BB), .CMD_GAP(GAP), .RD_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] out_vec();
      return {bus.cmd_en, bus.cmd, bus.addr, bus.wr_data, bus.data_mask, bus.wr_gnt,
              bus.wr_data_rd, bus.wr_done, bus.rd_gnt, bus.rd_data_out, bus.rd_data_out_valid,
              bus.rd_done, bus.busy, bus.error};
   endfunction

   task automatic step(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Write requester: presents base+index, advances on each consumed beat, rewinds after the burst.
   logic [31:0] wr_base;
   int          wr_idx;
   assign bus.wr_data_in = wr_base + 32'(wr_idx);
   assign bus.wr_mask_in = 4'(wr_idx);

   initial begin
      bit adv, clr;
      wr_idx = 0;
      forever begin
         @(negedge clk);
         adv = bus.wr_data_rd;
         clr = bus.wr_done || !rst_n;
         @(posedge clk);
         #1;
         if (clr) wr_idx = 0;
         else if (adv) wr_idx++;
      end
   end

   // PSRAM read responder: rsp_beats beats of 0xB0+i, first one rsp_lat cycles after cmd_en.
   int rsp_lat = 20, rsp_beats = 8, spur_req = 0, spur_done = 0;
   int r_lat, r_nb;

   initial begin
      bus.rd_data_valid = 1'b0;
      bus.rd_data       = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.cmd_en && !bus.cmd) begin
            r_lat = rsp_lat;
            r_nb  = rsp_beats;
            repeat (r_lat - 1) @(posedge clk);
            for (int i = 0; i < r_nb; i++) begin
               @(posedge clk);
               #1;
               bus.rd_data_valid = 1'b1;
               bus.rd_data       = 32'hB0 + 32'(i);
            end
            @(posedge clk);
            #1;
            bus.rd_data_valid = 1'b0;
            bus.rd_data       = '0;
         end else if (spur_req != spur_done) begin
            @(posedge clk);
            #1;
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = 32'hDEAD;
            @(posedge clk);
            #1;
            bus.rd_data_valid = 1'b0;
            bus.rd_data       = '0;
            spur_done++;
         end
      end
   end

   // Model: bursts are scheduled as cycle windows from the grant decision onward.
   int          free_cyc, cmd_cyc, rd_beats, wr_done_cyc, rd_done_cyc, kind, m_n;
   bit          m_err, last_wr, m_pick_wr;
   logic [20:0] m_addr;
   logic        e_wr, e_rd, e_cmd;
   logic [9:0]  exp_ctrl, act_ctrl;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            free_cyc = 0; kind = 0; m_err = 0; last_wr = 0; rd_beats = 0;
            cmd_cyc = NEVER; wr_done_cyc = -1; rd_done_cyc = -1; m_addr = '0;
         end else begin
            m_n   = cyc;
            e_wr  = !m_err && kind == 1 && m_n >= cmd_cyc && m_n < cmd_cyc + BB;
            e_rd  = !m_err && kind == 2 && m_n >= cmd_cyc && rd_beats < BB;
            e_cmd = (e_wr || e_rd) && m_n == cmd_cyc;
            exp_ctrl = {e_cmd, e_cmd && e_wr, e_cmd && e_wr, e_cmd && e_rd, e_wr,
                        !m_err && m_n == wr_done_cyc, e_rd && bus.rd_data_valid,
                        !m_err && m_n == rd_done_cyc, m_err || m_n < free_cyc, m_err};
            act_ctrl = {bus.cmd_en, bus.cmd, bus.wr_gnt, bus.rd_gnt, bus.wr_data_rd,
                        bus.wr_done, bus.rd_data_out_valid, bus.rd_done, bus.busy, bus.error};
            check("model_ctrl", act_ctrl, exp_ctrl);
            check("model_wdata", {bus.wr_data, bus.data_mask},
                  e_wr ? {bus.wr_data_in, bus.wr_mask_in} : 36'h0);
            if (e_cmd) check("model_addr", bus.addr, m_addr);
            if (e_rd && bus.rd_data_valid) check("model_rdata", bus.rd_data_out, bus.rd_data);

            if (!m_err) begin
               if (bus.rd_data_valid) begin
                  if (e_rd) begin
                     rd_beats++;
                     if (rd_beats == BB) begin
                        rd_done_cyc = m_n + 1;
                        free_cyc    = m_n + GAP + 1;
                     end
                  end else begin
                     m_err = 1;
                  end
               end
               if (e_rd && !m_err && rd_beats < BB && m_n == cmd_cyc + TMO - 1) m_err = 1;
               if (!m_err && m_n >= free_cyc && bus.init_done && (bus.wr_req || bus.rd_req)) begin
                  m_pick_wr = bus.wr_req && !(bus.rd_req && last_wr);
                  last_wr   = m_pick_wr;
                  cmd_cyc   = m_n + 1;
                  rd_beats  = 0;
                  if (m_pick_wr) begin
                     kind = 1; m_addr = bus.wr_addr;
                     free_cyc = m_n + 1 + BB + GAP; wr_done_cyc = m_n + 1 + BB;
                  end else begin
                     kind = 2; m_addr = bus.rd_addr; free_cyc = NEVER;
                  end
               end
            end
         end
      end
   end

   logic [31:0] beats[$];
   int          found, lat, cnt, ng, gc;
   int          gt[4];
   logic [3:0]  order;

   task automatic wait_idle(input string name);
      int ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!bus.busy) begin ok = 1; break; end
      end
      check(name, ok, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.init_done = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.wr_addr = '0; bus.rd_addr = '0; wr_base = 32'hA0;
      step(3);
      @(negedge clk);
      check("reset_outputs", out_vec(), '0);

      // No grants while calibration is pending, then first grant 2 cycles after init_done rises.
      @(posedge clk); #1;
      rst_n = 1'b1; bus.wr_addr = 21'h1234; bus.wr_req = 1'b1;
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.cmd_en || bus.wr_gnt) cnt++;
      end
      check("no_gnt_without_init", cnt, 0);
      @(posedge clk); #1;
      bus.init_done = 1'b1;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.wr_gnt) begin lat = i; break; end
      end
      check("init_to_wr_gnt", lat, 2);
      check("wr_cmd_addr", {bus.cmd, bus.addr}, {1'b1, 21'h1234});
      beats.delete();
      if (bus.wr_data_rd) beats.push_back(bus.wr_data);
      @(posedge clk); #1;
      bus.wr_req = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.wr_data_rd) beats.push_back(bus.wr_data);
         if (bus.wr_done) begin lat = i; break; end
      end
      check("wr_beat_count", beats.size(), BB);
      for (int i = 0; i < beats.size(); i++) check("wr_beat_value", beats[i], 32'hA0 + 32'(i));
      check("wr_done_offset", lat, BB);
      wait_idle("idle_after_write");

      // Read burst with beats arriving 20 cycles after cmd_en.
      @(posedge clk); #1;
      rsp_lat = 20; rsp_beats = 8; bus.rd_addr = 21'h0BEEF; bus.rd_req = 1'b1;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) begin found = 1; break; end
      end
      check("rd_gnt_seen", found, 1);
      check("rd_cmd_addr", {bus.cmd, bus.addr}, {1'b0, 21'h0BEEF});
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      beats.delete(); found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.rd_data_out_valid) beats.push_back(bus.rd_data_out);
         if (bus.rd_done) begin found = 1; break; end
      end
      check("rd_done_seen", found, 1);
      check("rd_beat_count", beats.size(), BB);
      for (int i = 0; i < beats.size(); i++) check("rd_beat_value", beats[i], 32'hB0 + 32'(i));
      check("rd_no_error", bus.error, 1'b0);
      wait_idle("idle_after_read");

      // Both requesters held from reset: W,R,W,R with fixed spacings.
      bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_addr = 21'h100; bus.rd_addr = 21'h200;
      rsp_lat = 3; rsp_beats = 8;
      do_reset();
      ng = 0; order = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.wr_gnt || bus.rd_gnt) begin
            order = {order[2:0], bus.wr_gnt};
            gt[ng] = cyc;
            ng++;
            if (ng == 4) break;
         end
      end
      check("alt_grant_count", ng, 4);
      check("alt_grant_order", order, 4'b1010);
      check("alt_spacing_wr", gt[1] - gt[0], BB + GAP + 1);
      check("alt_spacing_rd", gt[2] - gt[1], 26);
      check("alt_spacing_wr2", gt[3] - gt[2], BB + GAP + 1);
      @(posedge clk); #1;
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      wait_idle("idle_after_alt");

      // Short read: only 5 beats, error exactly RD_TIMEOUT cycles after cmd_en, then no grants.
      @(posedge clk); #1;
      rsp_lat = 4; rsp_beats = 5; bus.rd_addr = 21'h300; bus.rd_req = 1'b1;
      gc = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rd_gnt) begin gc = cyc; break; end
      end
      check("short_rd_gnt_seen", gc >= 0, 1'b1);
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.error) begin lat = cyc - gc; break; end
      end
      check("timeout_offset", lat, TMO);
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.rd_req = 1'b1;
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.wr_gnt || bus.rd_gnt || bus.cmd_en) cnt++;
      end
      check("no_gnt_in_error", cnt, 0);
      check("error_sticky", bus.error, 1'b1);

      // Stray rd_data_valid while idle traps into the error state.
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      do_reset();
      step(2);
      spur_req++;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.error) begin found = 1; break; end
      end
      check("spurious_valid_error", found, 1);
      check("spurious_not_forwarded", bus.rd_data_out_valid, 1'b0);

      // Reset during write beat 3: outputs clear at once, next grant is the write.
      bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_addr = 21'h400;
      do_reset();
      found = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.wr_gnt) begin found = 1; break; end
      end
      check("pre_reset_wr_gnt", found, 1);
      repeat (3) @(posedge clk);
      #1;
      check("beat3_in_progress", bus.wr_data_rd, 1'b1);
      rst_n = 1'b0;
      #1;
      check("reset_mid_burst", out_vec(), '0);
      step(2);
      rst_n = 1'b1;
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.wr_gnt || bus.rd_gnt) begin lat = {bus.wr_gnt, bus.rd_gnt}; break; end
      end
      check("first_gnt_after_reset", lat, 2);
      @(posedge clk); #1;
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      wait_idle("idle_at_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
